mm_interrupt_ctrl: RTL and testbench
====================================

# mm_interrupt_ctrl

Multi-channel memory-mapped interrupt controller for the core's data bus. It latches hardware and software interrupt requests into per-channel pending bits and arbitrates among enabled channels by fixed priority. The winning channel's vector PC is presented to the core over a valid/ready handshake, and new dispatch is blocked until the core writes end-of-interrupt. It is the parametrised successor to the single-vector, single-trigger interrupt register.

## Interface
- DATA_WIDTH, 32: bus data/address width and vector PC width.
- NUM_CHANNELS, 8: interrupt channels; legal range 1..16.
- BASE_ADDR, 32'h90000040: byte address of register block.
- clock  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- we  input  1  bus write strobe.
- re  input  1  bus read strobe.
- addr  input  DATA_WIDTH  bus byte address.
- data  input  DATA_WIDTH  bus write data.
- rdata  output  DATA_WIDTH  registered read data.
- irq_in  input  NUM_CHANNELS  hardware requests, synchronous to clock, rising-edge sensitive.
- int_valid  output  1  interrupt offered to core.
- int_ready  input  1  core accepts the offered interrupt.
- int_pc  output  DATA_WIDTH  vector PC of offered channel.
- int_id  output  4  index of offered channel.
- in_service  output  1  an interrupt was accepted and EOI has not yet been written.

## Operation
- Register map (byte offset from BASE_ADDR; full-width address equality; other addresses read 0, writes ignored):
  - 0x00+4*i VEC[i], RW, i<NUM_CHANNELS.
  - 0x40 ENABLE, RW, bit i enables channel i.
  - 0x44 PENDING: read returns pending bits; write-1-to-set is the software trigger.
  - 0x48 CLEAR: write-1-to-clear pending bits; reads 0.
  - 0x4C EOI/STATUS: any write ends service. Read returns {in_service at bit 31, int_valid at bit 30, int_id at bits 3:0}.
- Edge detect: irq_prev register; pending[i] is set on irq_in[i] & ~irq_prev[i], regardless of ENABLE.
- Eligible = pending & ENABLE. The lowest index wins.
- FSM states:
  - IDLE: if eligible is nonzero, latch int_id/int_pc from the winner and go to REQ.
  - REQ: int_valid=1, with int_id and int_pc held stable. On int_ready, clear pending[int_id] and go to SERVICE.
  - SERVICE: in_service=1. On EOI write, go to IDLE.
- Once REQ is entered, int_valid is never retracted. Clearing ENABLE or pending for the offered channel during REQ has no effect on the offer. A CLEAR write to that bit still clears it.
- Simultaneous pending set (edge or PENDING write) and clear (CLEAR write or acceptance) on the same bit in the same cycle: set wins.
- EOI write in IDLE or REQ: ignored.
- A VEC write while in REQ does not change the latched int_pc.
- Reset asserted mid-operation: all state is cleared immediately, and a pending offer is lost.

## Timing
- Reset values: rdata=0, int_valid=0, int_pc=0, int_id=0, in_service=0, all VEC/ENABLE/pending/irq_prev=0, FSM=IDLE.
- Write takes effect at the next rising edge.
- Read: re with addr at edge N gives rdata valid after edge N; rdata holds until the next re.
- irq_in rises before edge N: pending is set after N, and int_valid is high after N+1 (two-cycle latency). PENDING write at edge N has the same latency.
- int_valid&int_ready sampled at edge N: in_service=1 and int_valid=0 after N.
- EOI at edge N: IDLE after N, and the next int_valid is possible after N+1.
- irq_in held high produces one pending set only; it must fall and rise again to retrigger.

## Structure
- mm_interrupt_pkg: register offset localparams (OFF_VEC, OFF_ENABLE, OFF_PENDING, OFF_CLEAR, OFF_EOI), FSM state enum (IDLE, REQ, SERVICE), MAX_CHANNELS=16.
- One sub-module, mm_int_prio_enc: combinational lowest-index priority encoder (NUM_CHANNELS bits in, found + 4-bit index out).

## Test plan
- Reset: hold reset=0 and read all registers -> all 0, int_valid=0. Release reset and idle 5 cycles -> int_valid stays 0.
- Single hardware IRQ:
  - Stimulus: VEC[2]=0x00001000, ENABLE=0x04, pulse irq_in[2].
  - Response: int_valid two cycles later with int_pc=0x00001000, int_id=2.
  - Assert int_ready: in_service=1, PENDING reads 0. EOI returns to IDLE.
- Priority and blocking:
  - Stimulus: ENABLE=0xFF, PENDING write 0x28.
  - Response: offer id 3. Accept it: id 5 is not offered until EOI, then id 5 is offered.
- Masking: ENABLE=0, pulse irq_in[0] -> PENDING=0x01, no int_valid. Write ENABLE=0x01 -> int_valid two cycles later.
- Stall and race:
  - Hold int_ready=0 for 10 cycles -> int_valid, int_pc, int_id stable. Write VEC and ENABLE meanwhile -> offer unchanged.
  - Same-cycle CLEAR of bit 1 and irq_in[1] edge -> pending[1]=1.
- Async reset during SERVICE: drive reset low mid-cycle -> in_service and int_valid drop before the next edge, and all registers read 0 afterward.

Source files
------------

// File: rtl/mm_interrupt_pkg.sv
// mm_interrupt_pkg: register map offsets, FSM states and limits for the interrupt controller
package mm_interrupt_pkg;
  localparam int MAX_CHANNELS = 16;
  localparam int OFF_VEC      = 'h00;
  localparam int OFF_ENABLE   = 'h40;
  localparam int OFF_PENDING  = 'h44;
  localparam int OFF_CLEAR    = 'h48;
  localparam int OFF_EOI      = 'h4C;
  typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_e;
endpackage

// File: rtl/mm_int_prio_enc.sv
// mm_int_prio_enc: combinational lowest-index-wins priority encoder
module mm_int_prio_enc #(
  parameter int N = 8
) (
  input  logic [N-1:0] req_i,
  output logic         found_o,
  output logic [3:0]   idx_o
);
  // scan from the top so the lowest set index is the last one written
  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        found_o = 1'b1;
        idx_o   = 4'(i);
      end
    end
  end
endmodule

// File: rtl/mm_interrupt_ctrl.sv
// mm_interrupt_ctrl: memory-mapped fixed-priority interrupt controller with valid/ready dispatch and EOI
module mm_interrupt_ctrl
  import mm_interrupt_pkg::*;
#(
  parameter int                    DATA_WIDTH   = 32,
  parameter int                    NUM_CHANNELS = 8,
  parameter logic [DATA_WIDTH-1:0] BASE_ADDR    = 32'h90000040
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    we_i,
  input  logic                    re_i,
  input  logic [DATA_WIDTH-1:0]   addr_i,
  input  logic [DATA_WIDTH-1:0]   data_i,
  output logic [DATA_WIDTH-1:0]   rdata_o,
  input  logic [NUM_CHANNELS-1:0] irq_i,
  output logic                    int_valid_o,
  input  logic                    int_ready_i,
  output logic [DATA_WIDTH-1:0]   int_pc_o,
  output logic [3:0]              int_id_o,
  output logic                    in_service_o
);
  logic [DATA_WIDTH-1:0]   vec_q [MAX_CHANNELS];
  logic [NUM_CHANNELS-1:0] en_q, pend_q, prev_q, pend_d, set_m, clr_m;
  logic [DATA_WIDTH-1:0]   off, rdata_q, rdata_d, pc_q;
  logic [3:0]              vec_idx, win_idx, id_q;
  logic                    hit_vec, wr_en, wr_pend, wr_clr, wr_eoi, found, accept, valid_q, serv_q;
  state_e                  state_q;

  assign off     = addr_i - BASE_ADDR;
  assign hit_vec = (off - DATA_WIDTH'(OFF_VEC)) < DATA_WIDTH'(4 * NUM_CHANNELS) && off[1:0] == 2'b00;
  assign vec_idx = off[5:2];
  assign wr_en   = we_i && off == DATA_WIDTH'(OFF_ENABLE);
  assign wr_pend = we_i && off == DATA_WIDTH'(OFF_PENDING);
  assign wr_clr  = we_i && off == DATA_WIDTH'(OFF_CLEAR);
  assign wr_eoi  = we_i && off == DATA_WIDTH'(OFF_EOI);
  assign accept  = valid_q && int_ready_i;

  // sets (new edges, software trigger) override clears (CLEAR write, acceptance) on the same bit
  assign set_m  = (irq_i & ~prev_q) | (wr_pend ? data_i[NUM_CHANNELS-1:0] : '0);
  assign clr_m  = (wr_clr ? data_i[NUM_CHANNELS-1:0] : '0) | (accept ? NUM_CHANNELS'(1) << id_q : '0);
  assign pend_d = (pend_q & ~clr_m) | set_m;

  assign rdata_d = hit_vec                             ? vec_q[vec_idx] :
                   off == DATA_WIDTH'(OFF_ENABLE)      ? DATA_WIDTH'(en_q) :
                   off == DATA_WIDTH'(OFF_PENDING)     ? DATA_WIDTH'(pend_q) :
                   off == DATA_WIDTH'(OFF_EOI)         ? {serv_q, valid_q, {(DATA_WIDTH-6){1'b0}}, id_q} :
                   '0;

  mm_int_prio_enc #(.N(NUM_CHANNELS)) u_enc (
    .req_i  (pend_q & en_q),
    .found_o(found),
    .idx_o  (win_idx)
  );

  // bus-visible registers, edge history and registered read data
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < MAX_CHANNELS; i++) vec_q[i] <= '0;
      en_q    <= '0;
      pend_q  <= '0;
      prev_q  <= '0;
      rdata_q <= '0;
    end else begin
      if (we_i && hit_vec) vec_q[vec_idx] <= data_i;
      if (wr_en) en_q <= data_i[NUM_CHANNELS-1:0];
      if (re_i) rdata_q <= rdata_d;
      pend_q <= pend_d;
      prev_q <= irq_i;
    end
  end

  // dispatch FSM: the offer is latched on entry to REQ and never retracted until accepted
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      valid_q <= 1'b0;
      serv_q  <= 1'b0;
      id_q    <= '0;
      pc_q    <= '0;
    end else begin
      case (state_q)
        IDLE: if (found) begin
          state_q <= REQ;
          valid_q <= 1'b1;
          id_q    <= win_idx;
          pc_q    <= vec_q[win_idx];
        end
        REQ: if (int_ready_i) begin
          state_q <= SERVICE;
          valid_q <= 1'b0;
          serv_q  <= 1'b1;
        end
        SERVICE: if (wr_eoi) begin
          state_q <= IDLE;
          serv_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rdata_o      = rdata_q;
  assign int_valid_o  = valid_q;
  assign int_pc_o     = pc_q;
  assign int_id_o     = id_q;
  assign in_service_o = serv_q;
endmodule

// File: tb/tb_mm_interrupt_ctrl.sv
// tb_mm_interrupt_ctrl: table, directed and random checks of mm_interrupt_ctrl against a behavioural model
module tb_mm_interrupt_ctrl;
  localparam int          NC   = 8;
  localparam logic [31:0] BASE = 32'h90000040;

  logic          clk = 1'b0, rst_n = 1'b0, we = 1'b0, re = 1'b0, int_ready = 1'b0;
  logic [31:0]   addr = BASE, data = '0;
  logic [NC-1:0] irq = '0;
  logic [31:0]   rdata, int_pc;
  logic [3:0]    int_id;
  logic          int_valid, in_service;
  int            n_cmp = 0, n_bad = 0;

  always #5 clk = ~clk;

  mm_interrupt_ctrl #(.DATA_WIDTH(32), .NUM_CHANNELS(NC), .BASE_ADDR(BASE)) dut (
    .clk_i(clk), .rst_ni(rst_n), .we_i(we), .re_i(re), .addr_i(addr), .data_i(data),
    .rdata_o(rdata), .irq_i(irq), .int_valid_o(int_valid), .int_ready_i(int_ready),
    .int_pc_o(int_pc), .int_id_o(int_id), .in_service_o(in_service)
  );

  // behavioural model: register contents plus "an offer is outstanding" / "being serviced" flags
  logic [31:0]   m_vec [16];
  logic [NC-1:0] m_en, m_pend, m_prev;
  logic          m_offer, m_serv;
  logic [3:0]    m_id;
  logic [31:0]   m_pc, m_rd;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask

  task automatic m_reset();
    for (int i = 0; i < 16; i++) m_vec[i] = '0;
    m_en = '0; m_pend = '0; m_prev = '0;
    m_offer = 1'b0; m_serv = 1'b0; m_id = '0; m_pc = '0; m_rd = '0;
  endtask

  task automatic m_step();
    logic [31:0]   off;
    logic [NC-1:0] elig, low, set, clr, np;
    logic          vhit;
    off  = addr - BASE;
    vhit = off < 32'(4 * NC) && off[1:0] == 2'b00;
    set  = (irq & ~m_prev) | ((we && off == 32'h44) ? data[NC-1:0] : '0);
    clr  = ((we && off == 32'h48) ? data[NC-1:0] : '0) | ((m_offer && int_ready) ? NC'(1) << m_id : '0);
    np   = (m_pend & ~clr) | set;
    if (re) m_rd = vhit ? m_vec[off[5:2]] : off == 32'h40 ? {24'b0, m_en} : off == 32'h44 ? {24'b0, m_pend} :
                   off == 32'h4C ? {m_serv, m_offer, 26'b0, m_id} : 32'h0;
    elig = m_pend & m_en;
    if (m_offer) begin
      if (int_ready) begin m_offer = 1'b0; m_serv = 1'b1; end
    end else if (m_serv) begin
      if (we && off == 32'h4C) m_serv = 1'b0;
    end else if (elig != '0) begin
      low     = elig & (~elig + 1'b1);
      m_id    = 4'($clog2(low));
      m_pc    = m_vec[m_id];
      m_offer = 1'b1;
    end
    if (we && vhit) m_vec[off[5:2]] = data;
    if (we && off == 32'h40) m_en = data[NC-1:0];
    m_pend = np;
    m_prev = irq;
  endtask

  task automatic tick();
    if (rst_n) m_step(); else m_reset();
    @(posedge clk); #1;
    chk("valid", {31'b0, int_valid}, {31'b0, m_offer});
    chk("in_service", {31'b0, in_service}, {31'b0, m_serv});
    chk("id", {28'b0, int_id}, {28'b0, m_id});
    chk("pc", int_pc, m_pc);
    chk("rdata", rdata, m_rd);
  endtask

  task automatic wr(input logic [31:0] o, input logic [31:0] d);
    we = 1'b1; addr = BASE + o; data = d;
    tick();
    we = 1'b0;
  endtask

  task automatic rd(input logic [31:0] o, output logic [31:0] v);
    re = 1'b1; addr = BASE + o;
    tick();
    re = 1'b0;
    v = rdata;
  endtask

  typedef struct {
    bit          wr;
    logic [31:0] off;
    logic [31:0] d;
    logic [31:0] exp;
    string       name;
  } vec_t;

  vec_t        tbl [16];
  logic [31:0] offs [5] = '{32'h40, 32'h44, 32'h48, 32'h4C, 32'h50};
  logic [31:0] v;

  initial begin
    m_reset();
    // reset held: everything reads zero and nothing is offered
    for (int i = 0; i < 5; i++) begin
      rd(offs[i], v);
      chk("rst_rd", v, 32'h0);
      chk("rst_valid", {31'b0, int_valid}, 32'h0);
    end
    rst_n = 1'b1;
    repeat (5) tick();
    chk("idle_valid", {31'b0, int_valid}, 32'h0);

    // register map table
    tbl[0]  = '{1'b1, 32'h00, 32'h11,  32'h0,  "wr_vec0"};
    tbl[1]  = '{1'b1, 32'h1C, 32'h77,  32'h0,  "wr_vec7"};
    tbl[2]  = '{1'b1, 32'h40, 32'h1FF, 32'h0,  "wr_en"};
    tbl[3]  = '{1'b0, 32'h00, 32'h0,   32'h11, "rd_vec0"};
    tbl[4]  = '{1'b0, 32'h1C, 32'h0,   32'h77, "rd_vec7"};
    tbl[5]  = '{1'b0, 32'h20, 32'h0,   32'h0,  "rd_vec8_oob"};
    tbl[6]  = '{1'b0, 32'h40, 32'h0,   32'hFF, "rd_enable"};
    tbl[7]  = '{1'b0, 32'h48, 32'h0,   32'h0,  "rd_clear"};
    tbl[8]  = '{1'b0, 32'h02, 32'h0,   32'h0,  "rd_unaligned"};
    tbl[9]  = '{1'b0, 32'h44, 32'h0,   32'h0,  "rd_pending"};
    tbl[10] = '{1'b1, 32'h40, 32'h0,   32'h0,  "wr_en0"};
    tbl[11] = '{1'b0, 32'h4C, 32'h0,   32'h0,  "rd_status"};
    tbl[12] = '{1'b0, 32'h50, 32'h0,   32'h0,  "rd_beyond"};
    tbl[13] = '{1'b1, 32'h20, 32'h55,  32'h0,  "wr_oob"};
    tbl[14] = '{1'b0, 32'h20, 32'h0,   32'h0,  "rd_oob"};
    tbl[15] = '{1'b0, 32'h40, 32'h0,   32'h0,  "rd_enable0"};
    for (int i = 0; i < 16; i++) begin
      if (tbl[i].wr) wr(tbl[i].off, tbl[i].d);
      else begin
        rd(tbl[i].off, v);
        chk(tbl[i].name, v, tbl[i].exp);
      end
    end

    // single hardware IRQ with two-cycle latency
    wr(32'h08, 32'h1000);
    wr(32'h40, 32'h04);
    irq[2] = 1'b1; tick(); irq[2] = 1'b0;
    chk("lat_n_valid", {31'b0, int_valid}, 32'h0);
    tick();
    chk("lat_n1_valid", {31'b0, int_valid}, 32'h1);
    chk("irq_pc", int_pc, 32'h1000);
    chk("irq_id", {28'b0, int_id}, 32'h2);
    int_ready = 1'b1; tick(); int_ready = 1'b0;
    chk("acc_serv", {31'b0, in_service}, 32'h1);
    chk("acc_valid", {31'b0, int_valid}, 32'h0);
    rd(32'h44, v); chk("acc_pend", v, 32'h0);
    rd(32'h4C, v); chk("acc_status", v, 32'h80000002);
    wr(32'h4C, 32'h0);
    chk("eoi_serv", {31'b0, in_service}, 32'h0);

    // priority and blocking until EOI
    wr(32'h40, 32'hFF);
    wr(32'h44, 32'h28);
    tick();
    chk("prio_id3", {28'b0, int_id}, 32'h3);
    int_ready = 1'b1; tick(); int_ready = 1'b0;
    repeat (3) tick();
    chk("blocked", {31'b0, int_valid}, 32'h0);
    wr(32'h4C, 32'h0);
    chk("eoi_gap", {31'b0, int_valid}, 32'h0);
    tick();
    chk("prio_valid5", {31'b0, int_valid}, 32'h1);
    chk("prio_id5", {28'b0, int_id}, 32'h5);
    int_ready = 1'b1; tick(); int_ready = 1'b0;
    wr(32'h4C, 32'h0);

    // masking: pending latches while disabled, offer follows enable
    wr(32'h40, 32'h0);
    irq[0] = 1'b1; tick(); irq[0] = 1'b0; tick();
    rd(32'h44, v); chk("mask_pend", v, 32'h1);
    chk("mask_valid", {31'b0, int_valid}, 32'h0);
    wr(32'h40, 32'h1);
    chk("en_gap", {31'b0, int_valid}, 32'h0);
    tick();
    chk("en_valid", {31'b0, int_valid}, 32'h1);
    chk("en_pc", int_pc, 32'h11);

    // stall: offer stays stable across VEC/ENABLE/CLEAR writes
    repeat (10) tick();
    wr(32'h00, 32'hDEAD);
    wr(32'h40, 32'h0);
    wr(32'h48, 32'h1);
    chk("stall_valid", {31'b0, int_valid}, 32'h1);
    chk("stall_pc", int_pc, 32'h11);
    chk("stall_id", {28'b0, int_id}, 32'h0);
    rd(32'h44, v); chk("stall_clr", v, 32'h0);
    int_ready = 1'b1; tick(); int_ready = 1'b0;
    wr(32'h4C, 32'h0);

    // a held request sets pending only once
    irq[3] = 1'b1; repeat (3) tick();
    wr(32'h48, 32'h8);
    tick();
    rd(32'h44, v); chk("held_once", v, 32'h0);
    irq[3] = 1'b0; tick(); irq[3] = 1'b1; tick(); irq[3] = 1'b0;
    rd(32'h44, v); chk("retrigger", v, 32'h8);

    // same-cycle CLEAR and edge: set wins
    irq[1] = 1'b1;
    wr(32'h48, 32'h2);
    irq[1] = 1'b0;
    rd(32'h44, v); chk("race_pend", v, 32'hA);
    wr(32'h48, 32'hFF);

    // async reset during SERVICE
    wr(32'h00, 32'h123);
    wr(32'h40, 32'h1);
    wr(32'h44, 32'h1);
    tick();
    int_ready = 1'b1; tick(); int_ready = 1'b0;
    chk("pre_rst_serv", {31'b0, in_service}, 32'h1);
    #2 rst_n = 1'b0;
    m_reset();
    #1;
    chk("arst_serv", {31'b0, in_service}, 32'h0);
    chk("arst_valid", {31'b0, int_valid}, 32'h0);
    tick();
    #2 rst_n = 1'b1;
    rd(32'h00, v); chk("post_vec0", v, 32'h0);
    rd(32'h40, v); chk("post_en", v, 32'h0);
    rd(32'h44, v); chk("post_pend", v, 32'h0);
    rd(32'h4C, v); chk("post_status", v, 32'h0);

    // random traffic against the model
    for (int n = 0; n < 3000; n++) begin
      int k;
      k = int'($urandom_range(0, 13));
      we = ($urandom_range(0, 3) == 0);
      re = $urandom_range(0, 1) == 1;
      addr = BASE + (k < 9 ? 32'(k * 4) : offs[k - 9]);
      data = $urandom;
      for (int i = 0; i < NC; i++) if ($urandom_range(0, 7) == 0) irq[i] = ~irq[i];
      int_ready = ($urandom_range(0, 2) == 0);
      tick();
    end
    we = 1'b0; re = 1'b0; int_ready = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
